// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART-side sharing logic.
//   UART_DATA_W : width of one serial payload byte.
//   arb_state_e : scheduler states (IDLE, SEND, GAP).
//   clog2()     : ceiling log2, usable in parameter and port declarations.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // Returns 0 for inputs up to 1, so a 1-bit-minimum guard is the caller's job.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req   : request vector, one bit per requester.
//   ptr   : index searched first; the search wraps upward from here.
//   grant : one-hot grant of the first requesting index at or after ptr,
//           all-zero when nothing requests.
module rr_arbiter import uart_pkg::*; #(
  parameter  int N  = 4,
  localparam int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic found;

  // Distance k from the pointer is the priority: the first k that lands on
  // an active request wins, and the found flag blocks every later match.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i == ((int'(ptr) + k) % N))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler that shares one TX serializer
// between N_REQ byte producers, with a watchdog on the TX completion pulse.
//   clk, reset  : rising-edge clock, synchronous active-high reset.
//   req_valid   : per-requester byte offer.
//   req_data    : byte i at req_data[8*i+7:8*i], stable while req_valid[i].
//   req_ready   : one-hot-or-zero accept, combinational, only in IDLE.
//   done        : one-cycle pulse to the owner when its frame ends or aborts.
//   tx_d_in     : byte presented to TX, held for the whole frame.
//   tx_start    : registered start level to TX.
//   tx_done     : one-clock pulse from TX at the end of the stop bit.
//   busy        : high whenever the scheduler is not in IDLE.
//   grant_id    : current owner; keeps its last value while IDLE.
//   timeout_err : sticky watchdog flag, cleared only by reset.
//
// Handshake: a byte transfers on any rising edge where req_valid[i] and
// req_ready[i] are both high; req_ready never depends on state other than
// IDLE, and a requester may drop req_valid before ready without penalty.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter  int N_REQ          = 4,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int ID_W           = clog2(N_REQ),
  localparam int WD_W           = clog2(TIMEOUT_CYCLES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ-1:0]             done,
  output logic [UART_DATA_W-1:0]       tx_d_in,
  output logic                         tx_start,
  input  logic                         tx_done,
  output logic                         busy,
  output logic [ID_W-1:0]              grant_id,
  output logic                         timeout_err
);

  arb_state_e             state;
  logic [ID_W-1:0]        rr_ptr;
  logic [WD_W-1:0]        wd_cnt;
  logic [N_REQ-1:0]       grant;
  logic [ID_W-1:0]        winner;
  logic [ID_W-1:0]        next_ptr;
  logic [UART_DATA_W-1:0] win_data;
  logic                   handshake;
  logic                   wd_expired;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    winner   = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        winner   = ID_W'(i);
        win_data = req_data[UART_DATA_W*i +: UART_DATA_W];
      end
    end
  end

  // Explicit wrap so non-power-of-two requester counts stay in range.
  assign next_ptr   = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
  assign req_ready  = (state == ST_IDLE) ? grant : '0;
  assign handshake  = |(req_valid & req_ready);
  assign busy       = (state != ST_IDLE);
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      wd_cnt      <= '0;
      tx_start    <= 1'b0;
      tx_d_in     <= '0;
      done        <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          // A tx_done arriving here belongs to a frame we no longer own.
          if (handshake) begin
            tx_d_in  <= win_data;
            grant_id <= winner;
            rr_ptr   <= next_ptr;
            wd_cnt   <= '0;
            tx_start <= 1'b1;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          // tx_done is checked first so a simultaneous expiry is not an error.
          if (tx_done) begin
            tx_start <= 1'b0;
            done     <= N_REQ'(1) << grant_id;
            state    <= ST_GAP;
          end else if (wd_expired) begin
            tx_start    <= 1'b0;
            done        <= N_REQ'(1) << grant_id;
            timeout_err <= 1'b1;
            state       <= ST_GAP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          // One cycle of start low so TX cannot see a stale start level.
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: bench for uart_tx_arbiter with a baud-tick driven TX
// model (divisor 4) on the main instance and a directly driven tx_done on a
// second instance configured with a 16-cycle watchdog.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   done;
  logic [7:0]     tx_d_in;
  logic           tx_start;
  logic           tx_done = 1'b0;
  logic           busy;
  logic [1:0]     grant_id;
  logic           timeout_err;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(128)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .done        (done),
    .tx_d_in     (tx_d_in),
    .tx_start    (tx_start),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  // ---------------- watchdog instance ----------------
  logic [N-1:0]   req_valid_w;
  logic [8*N-1:0] req_data_w;
  logic [N-1:0]   req_ready_w;
  logic [N-1:0]   done_w;
  logic [7:0]     tx_d_in_w;
  logic           tx_start_w;
  logic           tx_done_w;
  logic           busy_w;
  logic [1:0]     grant_id_w;
  logic           timeout_err_w;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(16)) dut_wd (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid_w),
    .req_data    (req_data_w),
    .req_ready   (req_ready_w),
    .done        (done_w),
    .tx_d_in     (tx_d_in_w),
    .tx_start    (tx_start_w),
    .tx_done     (tx_done_w),
    .busy        (busy_w),
    .grant_id    (grant_id_w),
    .timeout_err (timeout_err_w)
  );

  // ---------------- baud generator + TX model ----------------
  // Everything moves on the baud tick; the model is never reset so a frame
  // in flight finishes on its own, like the real serializer.
  logic [1:0] baud_div = 2'd0;
  logic       m_busy   = 1'b0;
  logic [8:0] m_frame  = 9'h1ff;
  logic [3:0] m_bit    = 4'd0;
  logic       tx_line  = 1'b1;

  always @(posedge clk) begin
    baud_div <= baud_div + 2'd1;
    tx_done  <= 1'b0;
    if (baud_div == 2'd3) begin
      if (!m_busy) begin
        if (tx_start) begin
          m_busy  <= 1'b1;
          m_frame <= {1'b1, tx_d_in};
          m_bit   <= 4'd0;
          tx_line <= 1'b0;
        end
      end else if (m_bit == 4'd9) begin
        m_busy  <= 1'b0;
        tx_done <= 1'b1;
      end else begin
        tx_line <= m_frame[m_bit];
        m_bit   <= m_bit + 4'd1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [10:0] exp_q[$];       // {owner id, byte} per tx_start rise
  logic [N-1:0] exp_done_q[$]; // done vector per completed frame
  logic [7:0]  exp_line_q[$];  // byte decoded from the serial line

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_fail(input string name);
    chk_cnt++;
    $display("FAIL %s: event with no expectation or bound expired", name);
  endtask

  // tx_start rise monitor: owner/byte from the expected queue, plus the gap.
  logic start_prev = 1'b0;
  int   low_run    = 0;
  initial forever begin
    logic [10:0] e;
    @(negedge clk);
    if (!reset && tx_start && !start_prev) begin
      if (exp_q.size() == 0) chk_fail("start_unexpected");
      else begin
        e = exp_q.pop_front();
        chk("frame_owner", 32'(grant_id), 32'(e[10:8]));
        chk("frame_byte", 32'(tx_d_in), 32'(e[7:0]));
        chk("start_low_gap_ge2", 32'(low_run >= 2), 32'd1);
      end
    end
    low_run    = tx_start ? 0 : low_run + 1;
    start_prev = tx_start;
  end

  // done monitor: every pulse must be expected and follow tx_done by one cycle.
  logic tx_done_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!reset && done != '0) begin
      if (exp_done_q.size() == 0) chk_fail("done_unexpected");
      else begin
        chk("done_vector", 32'(done), 32'(exp_done_q.pop_front()));
        chk("done_after_tx_done", 32'(tx_done_prev), 32'd1);
      end
    end
    tx_done_prev = tx_done;
  end

  // Serial line decoder: samples mid-bit, LSB first.
  logic       dec_busy = 1'b0;
  int         dec_cnt  = 0;
  logic [7:0] dec_byte = 8'h00;
  initial forever begin
    @(negedge clk);
    if (!dec_busy) begin
      if (tx_line == 1'b0) begin
        dec_busy = 1'b1;
        dec_cnt  = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt >= 6 && dec_cnt <= 34 && ((dec_cnt - 6) % 4 == 0))
        dec_byte[(dec_cnt - 6) / 4] = tx_line;
      if (dec_cnt == 38) begin
        chk("line_stop_bit", 32'(tx_line), 32'd1);
        if (exp_line_q.size() == 0) chk_fail("line_unexpected");
        else chk("line_byte", 32'(dec_byte), 32'(exp_line_q.pop_front()));
        dec_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Holds mask on req_valid until n handshakes have happened, then drops it.
  task automatic hold_until(input logic [N-1:0] mask, input int n);
    int hs;
    int budget;
    hs = 0;
    budget = 0;
    @(posedge clk); #1;
    req_valid = mask;
    while (hs < n && budget < 2000) begin
      @(negedge clk);
      if ((req_valid & req_ready) != '0) hs++;
      @(posedge clk);
      budget++;
    end
    #1 req_valid = '0;
    if (hs < n) chk_fail("handshake_budget");
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || m_busy || dec_busy || exp_done_q.size() != 0 ||
                exp_line_q.size() != 0) && n < 3000);
    if (n >= 3000) chk_fail("drain_budget");
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: bench did not finish");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    int dn;
    int early;
    reset = 1'b1;
    req_valid = '0; req_data = '0;
    req_valid_w = '0; req_data_w = '0; tx_done_w = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_d_in", 32'(tx_d_in), 32'd0);
    chk("rst_wd_busy", 32'(busy_w), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Single request, byte 0x99 from requester 0.
    req_data = 32'h0000_0099;
    exp_q.push_back({3'd0, 8'h99});
    exp_done_q.push_back(4'b0001);
    exp_line_q.push_back(8'h99);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("single_ready_same_cycle", 32'(req_ready), 32'h1);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("single_tx_start_next", 32'(tx_start), 32'd1);
    chk("single_busy_next", 32'(busy), 32'd1);
    chk("single_tx_d_in", 32'(tx_d_in), 32'h99);
    wait_drain();

    // Contention from pointer 0: order 0,1,2,3,0.
    pulse_reset();
    req_data = 32'hA3A2_A1A0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({3'(i % 4), 8'hA0 + 8'(i % 4)});
      exp_done_q.push_back(4'b0001 << (i % 4));
      exp_line_q.push_back(8'hA0 + 8'(i % 4));
    end
    hold_until(4'b1111, 5);
    wait_drain();

    // Pointer fairness: 2 served, then 0 and 3 -> 3 before 0.
    req_data = 32'hB3B2_B1B0;
    exp_q.push_back({3'd2, 8'hB2}); exp_done_q.push_back(4'b0100); exp_line_q.push_back(8'hB2);
    exp_q.push_back({3'd3, 8'hB3}); exp_done_q.push_back(4'b1000); exp_line_q.push_back(8'hB3);
    exp_q.push_back({3'd0, 8'hB0}); exp_done_q.push_back(4'b0001); exp_line_q.push_back(8'hB0);
    hold_until(4'b0100, 1);
    hold_until(4'b1001, 2);
    wait_drain();

    // Reset 5 baud ticks into byte 0xDA from requester 1.
    req_data = 32'h0000_DA00;
    exp_q.push_back({3'd1, 8'hDA});
    exp_line_q.push_back(8'hDA);
    hold_until(4'b0010, 1);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_tx_start", 32'(tx_start), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_grant_id", 32'(grant_id), 32'd0);
    chk("midrst_tx_d_in", 32'(tx_d_in), 32'd0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done != '0) dn++;
    end
    chk("midrst_no_done", 32'(dn), 32'd0);
    wait_drain();
    // Pointer back at 0: with 0 and 3 offered, 0 must win.
    req_data = 32'hC300_00C0;
    exp_q.push_back({3'd0, 8'hC0});
    exp_done_q.push_back(4'b0001);
    exp_line_q.push_back(8'hC0);
    hold_until(4'b1001, 1);
    wait_drain();

    // Watchdog instance: timeout 16 cycles after SEND entry.
    req_data_w = 32'h0000_0055;
    @(posedge clk); #1 req_valid_w = 4'b0001;
    @(negedge clk);
    chk("wd_ready", 32'(req_ready_w), 32'h1);
    @(posedge clk); #1 req_valid_w = '0;
    early = 0;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
      if (done_w != '0 || timeout_err_w) early++;
    end
    chk("wd_no_early_abort", 32'(early), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("wd_timeout_done", 32'(done_w), 32'h1);
    chk("wd_timeout_err", 32'(timeout_err_w), 32'd1);
    chk("wd_timeout_start_low", 32'(tx_start_w), 32'd0);
    chk("wd_gap_busy", 32'(busy_w), 32'd1);
    @(negedge clk);
    chk("wd_idle_after_gap", 32'(busy_w), 32'd0);

    // Good frame afterwards: timeout_err stays set.
    req_data_w = 32'h0000_6600;
    @(posedge clk); #1 req_valid_w = 4'b0010;
    @(posedge clk); #1 req_valid_w = '0;
    repeat (2) @(posedge clk);
    #1 tx_done_w = 1'b1;
    @(posedge clk); #1 tx_done_w = 1'b0;
    @(negedge clk);
    chk("wd_good_done", 32'(done_w), 32'h2);
    chk("wd_good_owner", 32'(grant_id_w), 32'd1);
    chk("wd_err_sticky", 32'(timeout_err_w), 32'd1);
    // tx_done while idle is ignored.
    repeat (2) @(posedge clk);
    #1 tx_done_w = 1'b1;
    @(posedge clk); #1 tx_done_w = 1'b0;
    @(negedge clk);
    chk("wd_idle_tx_done_busy", 32'(busy_w), 32'd0);
    chk("wd_idle_tx_done_done", 32'(done_w), 32'd0);

    // Coincidence: tx_done on the expiry cycle; reset clears the sticky flag.
    pulse_reset();
    @(negedge clk);
    chk("wd_err_cleared", 32'(timeout_err_w), 32'd0);
    req_data_w = 32'h0077_0000;
    @(posedge clk); #1 req_valid_w = 4'b0100;
    @(posedge clk); #1 req_valid_w = '0;
    repeat (15) @(posedge clk);
    #1 tx_done_w = 1'b1;
    @(negedge clk);
    chk("coin_no_done_before", 32'(done_w), 32'd0);
    @(posedge clk); #1 tx_done_w = 1'b0;
    @(negedge clk);
    chk("coin_done", 32'(done_w), 32'h4);
    chk("coin_no_timeout_err", 32'(timeout_err_w), 32'd0);
    chk("coin_gap_busy", 32'(busy_w), 32'd1);

    repeat (4) @(negedge clk);
    chk("leftover_frames", 32'(exp_q.size()), 32'd0);
    chk("leftover_done", 32'(exp_done_q.size()), 32'd0);
    chk("leftover_line", 32'(exp_line_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `TX` serializer between `N_REQ` byte producers. It sits between the producers and the `TX` instance driven by `BaudRateGenerator`. It accepts one byte at a time over a valid/ready handshake and drives `d_in`/`tx_start` to `TX`. It releases `TX` on `tx_done`, or on a watchdog timeout if `tx_done` never arrives.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 4096: clk cycles allowed in SEND before abort, ≥ 16.
- `clk` in 1: system clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in N_REQ: bit i means requester i offers a byte.
- `req_data` in 8*N_REQ: byte i is `req_data[8*i+7:8*i]`; must be stable while `req_valid[i]` is high.
- `req_ready` out N_REQ: one-hot-or-zero accept, combinational.
- `done` out N_REQ: one-cycle pulse to the owner when its byte finishes or is aborted.
- `tx_d_in` out 8: byte to `TX.d_in`.
- `tx_start` out 1: to `TX.tx_start`, registered.
- `tx_done` in 1: from `TX`; a one-clk pulse at the end of the stop bit.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out clog2(N_REQ): current owner; holds its last value in IDLE.
- `timeout_err` out 1: sticky; cleared only by `reset`.

## Operation
- States: IDLE, SEND, GAP.
- **IDLE**
  - Winner = first i with `req_valid[i]`, searching from `rr_ptr` upward with wrap-around.
  - `req_ready[winner]`=1 in the same cycle. Handshake = valid & ready.
  - On handshake:
    - capture the byte into `tx_d_in`;
    - set `grant_id`=winner;
    - set `rr_ptr` = (winner+1) mod N_REQ;
    - go to SEND.
  - `tx_done` seen in IDLE is ignored.
- **SEND**
  - `tx_start`=1 and `tx_d_in` held constant. `req_ready`=0.
  - The watchdog counter increments every cycle.
  - On `tx_done`: go to GAP and pulse `done[grant_id]`.
  - If the counter reaches TIMEOUT_CYCLES-1 with no `tx_done`:
    - go to GAP;
    - pulse `done[grant_id]`;
    - set `timeout_err`=1.
  - If `tx_done` and the timeout occur in the same cycle, the `tx_done` path wins and `timeout_err` is not set.
- **GAP**
  - Exactly one cycle with `tx_start`=0. This guarantees `TX` sees start deasserted before any next frame.
  - Then go to IDLE.
- Fairness: a requester that holds `req_valid` continuously is served within N_REQ frames.
- The pointer advances only on a handshake. Requests that are not granted keep their place.
- The watchdog counter is clog2(TIMEOUT_CYCLES) bits wide. It clears on entry to SEND and never wraps.
- Dropping `req_valid` before ready is allowed; that request is simply lost.

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0, `tx_start`=0, `tx_d_in`=0;
  - `req_ready`=0 (IDLE with no valid), `done`=0, `busy`=0, `grant_id`=0, `timeout_err`=0.
- Handshake at cycle c, so:
  - c+1: `tx_start`=1, `busy`=1, `tx_d_in` valid.
- `tx_done` at cycle k, so:
  - k+1: `tx_start`=0, `done` pulse, state GAP;
  - k+2: IDLE, and a new handshake is possible;
  - k+3: `tx_start`=1 for the next frame.
- Minimum gap between frames: 2 clk with `tx_start` low. This relies on the `BaudRateGenerator` divisor being ≥ 4 clk, so `TX` cannot re-trigger on the stale start level.
- Reset asserted mid-SEND:
  - next cycle all outputs are at reset values and `tx_start` drops;
  - the frame already shifting in `TX` completes on its own;
  - its `tx_done` arrives in IDLE and is ignored;
  - no `done` pulse is issued for the aborted owner.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, SEND, GAP);
  - the `UART_DATA_W`=8 constant;
  - a `clog2` helper function.
- Natural sub-module: `rr_arbiter`, parameterized by N. Inputs are the request vector and the pointer; output is the one-hot grant. It is combinational and reusable for later RX-side sharing.
- The FSM, data register, watchdog and pointer stay in `uart_tx_arbiter`.
- The bench instantiates `BaudRateGenerator` + `TX` + `uart_tx_arbiter` together.

## Test plan
- Single request: `req_valid`=0001, byte 8'h99.
  - `req_ready[0]` is high in the same cycle.
  - `tx_start` is high one cycle later.
  - `tx` line shows start, 10011001 LSB-first, stop.
  - `done[0]` pulses one cycle after `tx_done`.
- Contention: all four valid, with bytes 8'hA0..8'hA3 held high.
  - Frames go out in order 0,1,2,3,0.
  - Each requester gets exactly one frame per 4.
  - `tx_start` is low for ≥ 2 clk between frames.
- Pointer fairness: requester 2 served, then 0 and 3 both valid.
  - 3 is granted before 0.
- Timeout: stubbed `TX` that never pulses `tx_done`, TIMEOUT_CYCLES=16.
  - `done[grant]` and `timeout_err` rise 16 cycles after SEND entry.
  - `timeout_err` stays high through later good frames until `reset`.
- Reset mid-frame: `reset` asserted 5 baud ticks into byte 8'hDA.
  - `tx_start`=0 and `busy`=0 the next cycle.
  - The late `tx_done` produces no `done` pulse.
  - A new request after reset is accepted normally with `rr_ptr`=0.
- Coincidence: `tx_done` on the same cycle the watchdog expires.
  - `done` pulses.
  - `timeout_err` remains 0.
